rom_loader: RTL and testbench

- UART boot loader: receives a framed program image over a serial line and writes it word by word into the instruction ROM's write port.
- It is the writer side of the instruction memory that the fetch stage reads.
- Holds the CPU pipeline in reset while loading; releases it once a frame has fully loaded and its checksum verifies.
- Sits at the top level beside the CPU, between the board RX pin and the ROM.

---
 rtl/rom_loader.sv | 211 +++++++++++++++++++++
 tb/tb_rom_loader.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_loader.sv
// UART boot loader: receives a framed, checksummed program image over 8N1 serial and
// writes it word by word into the instruction ROM, holding the CPU in reset until verified.
module rom_loader #(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned BAUD   = 115200,
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx,
  output logic              o_we,
  output logic [ADDR_W-1:0] o_waddr,
  output logic [31:0]       o_wdata,
  output logic              o_cpu_rst,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned MAX_WORDS    = 2 ** ADDR_W;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {LClo, LChi, LData, LCsum, LDone, LErr} ld_state_e;

  // ---------------- RX synchroniser ----------------
  logic r_sync1, r_sync2, r_sync_prev;
  logic w_fall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_sync_prev <= 1'b1;
    end else begin
      r_sync1     <= uart_rx;
      r_sync2     <= r_sync1;
      r_sync_prev <= r_sync2;
    end
  end

  assign w_fall = r_sync_prev & ~r_sync2;

  // ---------------- RX FSM ----------------
  rx_state_e        r_rx_state, w_rx_state_next;
  logic [CNT_W-1:0] r_clk_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_byte;
  logic             r_byte_valid, r_frame_err;
  logic             w_bit_tick, w_half_tick;

  assign w_bit_tick  = (r_clk_cnt == BIT_LAST);
  assign w_half_tick = (r_clk_cnt == HALF_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_rx_state <= RxIdle;
    else     r_rx_state <= w_rx_state_next;
  end

  always_comb begin
    w_rx_state_next = r_rx_state;
    case (r_rx_state)
      RxIdle:  if (w_fall) w_rx_state_next = RxStart;
      RxStart: if (w_half_tick) w_rx_state_next = r_sync2 ? RxIdle : RxData;
      RxData:  if (w_bit_tick && (r_bit_idx == 3'd7)) w_rx_state_next = RxStop;
      RxStop:  if (w_bit_tick) w_rx_state_next = RxIdle;
      default: w_rx_state_next = RxIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_cnt    <= '0;
      r_bit_idx    <= '0;
      r_shift      <= '0;
      r_byte       <= '0;
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_byte_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      case (r_rx_state)
        RxIdle: begin
          r_clk_cnt <= '0;
          r_bit_idx <= '0;
        end
        RxStart: r_clk_cnt <= w_half_tick ? '0 : r_clk_cnt + 1'b1;
        RxData: begin
          if (w_bit_tick) begin
            r_clk_cnt <= '0;
            r_shift   <= {r_sync2, r_shift[7:1]};
            r_bit_idx <= r_bit_idx + 1'b1;
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        RxStop: begin
          if (w_bit_tick) begin
            r_clk_cnt <= '0;
            if (r_sync2) begin
              r_byte_valid <= 1'b1;
              r_byte       <= r_shift;
            end else begin
              r_frame_err <= 1'b1;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + 1'b1;
          end
        end
        default: r_clk_cnt <= '0;
      endcase
    end
  end

  // ---------------- Loader FSM ----------------
  ld_state_e         r_ld_state, w_ld_state_next;
  logic [7:0]        r_cnt_lo;
  logic [7:0]        r_xor;
  logic [15:0]       r_words_left;
  logic [1:0]        r_byte_idx;
  logic [ADDR_W-1:0] r_word_idx;
  logic [23:0]       r_word;
  logic              r_we;
  logic [ADDR_W-1:0] r_waddr;
  logic [31:0]       r_wdata;
  logic [15:0]       w_count;

  assign w_count = {r_byte, r_cnt_lo};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ld_state <= LClo;
    else     r_ld_state <= w_ld_state_next;
  end

  always_comb begin
    w_ld_state_next = r_ld_state;
    if (r_frame_err && (r_ld_state != LDone) && (r_ld_state != LErr)) begin
      w_ld_state_next = LErr;
    end else if (r_byte_valid) begin
      case (r_ld_state)
        LClo:  w_ld_state_next = LChi;
        LChi: begin
          if (32'(w_count) > MAX_WORDS) w_ld_state_next = LErr;
          else if (w_count == 16'd0)    w_ld_state_next = LCsum;
          else                          w_ld_state_next = LData;
        end
        LData: if ((r_byte_idx == 2'd3) && (r_words_left == 16'd1)) w_ld_state_next = LCsum;
        LCsum: w_ld_state_next = (r_byte == r_xor) ? LDone : LErr;
        LDone: w_ld_state_next = LChi;  // this byte is the next frame's CNT_LO
        default: w_ld_state_next = r_ld_state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_lo     <= '0;
      r_xor        <= '0;
      r_words_left <= '0;
      r_byte_idx   <= '0;
      r_word_idx   <= '0;
      r_word       <= '0;
      r_we         <= 1'b0;
      r_waddr      <= '0;
      r_wdata      <= '0;
    end else begin
      r_we <= 1'b0;
      if (r_byte_valid) begin
        case (r_ld_state)
          LClo, LDone: begin
            r_cnt_lo <= r_byte;
            r_xor    <= r_byte;
          end
          LChi: begin
            r_xor        <= r_xor ^ r_byte;
            r_words_left <= w_count;
            r_byte_idx   <= '0;
            r_word_idx   <= '0;
          end
          LData: begin
            r_xor      <= r_xor ^ r_byte;
            r_word     <= {r_byte, r_word[23:8]};
            r_byte_idx <= r_byte_idx + 1'b1;
            if (r_byte_idx == 2'd3) begin
              r_we         <= 1'b1;
              r_waddr      <= r_word_idx;
              r_wdata      <= {r_byte, r_word};
              r_word_idx   <= r_word_idx + 1'b1;
              r_words_left <= r_words_left - 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    o_cpu_rst = (r_ld_state != LDone);
    o_done    = (r_ld_state == LDone);
    o_err     = (r_ld_state == LErr);
  end

  assign o_we    = r_we;
  assign o_waddr = r_waddr;
  assign o_wdata = r_wdata;

endmodule

// File: tb/tb_rom_loader.sv
// Self-checking bench for rom_loader: table-driven frames, hand-written corner sequences
// and randomized frames checked against a frame-level reference model.
module tb_rom_loader;

  localparam int unsigned CLK_HZ = 1_000_000;
  localparam int unsigned BAUD   = 125_000;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CPB    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              uart_rx = 1'b1;
  logic              o_we;
  logic [ADDR_W-1:0] o_waddr;
  logic [31:0]       o_wdata;
  logic              o_cpu_rst, o_done, o_err;

  rom_loader #(
    .CLK_HZ(CLK_HZ),
    .BAUD  (BAUD),
    .ADDR_W(ADDR_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rx  (uart_rx),
    .o_we     (o_we),
    .o_waddr  (o_waddr),
    .o_wdata  (o_wdata),
    .o_cpu_rst(o_cpu_rst),
    .o_done   (o_done),
    .o_err    (o_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  wr_t got_q[$];

  always @(negedge clk) if (o_we) got_q.push_back({o_waddr, o_wdata});

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    uart_rx = stop_ok;
    repeat (CPB) @(negedge clk);
    uart_rx = 1'b1;
    if (!stop_ok) repeat (CPB) @(negedge clk);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    got_q.delete();
  endtask

  typedef struct {
    logic [7:0] b [12];
    int         n;
    int         bad_stop;
    int         exp_we;
    bit         exp_done;
    bit         exp_err;
  } vec_t;

  vec_t       vecs[5];
  logic [7:0] fr[$];
  logic [31:0] words[$];
  logic [7:0] csum;
  int         n_words;
  bit         corrupt, exp_done, exp_err, prev_err;

  initial begin
    // Checksum is the XOR of the ten preceding bytes: 0xB2.
    vecs[0].b = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00,
                  8'hB2, 8'h00};
    vecs[0].n = 11; vecs[0].bad_stop = -1; vecs[0].exp_we = 2;
    vecs[0].exp_done = 1'b1; vecs[0].exp_err = 1'b0;
    vecs[1].b = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00,
                  8'hB3, 8'h00};
    vecs[1].n = 11; vecs[1].bad_stop = -1; vecs[1].exp_we = 2;
    vecs[1].exp_done = 1'b0; vecs[1].exp_err = 1'b1;
    vecs[2].b = vecs[0].b;
    vecs[2].n = 11; vecs[2].bad_stop = 3; vecs[2].exp_we = 0;
    vecs[2].exp_done = 1'b0; vecs[2].exp_err = 1'b1;
    vecs[3].b = '{8'h11, 8'h00, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00};
    vecs[3].n = 4; vecs[3].bad_stop = -1; vecs[3].exp_we = 0;
    vecs[3].exp_done = 1'b0; vecs[3].exp_err = 1'b1;
    vecs[4].b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                  8'h00, 8'h00};
    vecs[4].n = 3; vecs[4].bad_stop = -1; vecs[4].exp_we = 0;
    vecs[4].exp_done = 1'b1; vecs[4].exp_err = 1'b0;

    // Reset values, sampled inside the reset window.
    repeat (3) @(negedge clk);
    check("rst_we", o_we, 0);
    check("rst_waddr", o_waddr, 0);
    check("rst_wdata", o_wdata, 0);
    check("rst_cpu_rst", o_cpu_rst, 1);
    check("rst_done", o_done, 0);
    check("rst_err", o_err, 0);

    for (int v = 0; v < 5; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].b[i], i != vecs[v].bad_stop);
      repeat (30) @(negedge clk);
      check($sformatf("vec%0d_nwrites", v), got_q.size(), vecs[v].exp_we);
      check($sformatf("vec%0d_done", v), o_done, vecs[v].exp_done);
      check($sformatf("vec%0d_err", v), o_err, vecs[v].exp_err);
      check($sformatf("vec%0d_cpu_rst", v), o_cpu_rst, !vecs[v].exp_done);
      if (v == 0 && got_q.size() == 2) begin
        check("vec0_w0_addr", got_q[0].addr, 0);
        check("vec0_w0_data", got_q[0].data, 32'h0010_0513);
        check("vec0_w1_addr", got_q[1].addr, 1);
        check("vec0_w1_data", got_q[1].data, 32'h0020_0593);
      end
    end

    // Error is sticky: a good frame after a bad checksum is ignored.
    do_reset();
    for (int i = 0; i < vecs[1].n; i++) send_byte(vecs[1].b[i], 1'b1);
    for (int i = 0; i < vecs[0].n; i++) send_byte(vecs[0].b[i], 1'b1);
    repeat (30) @(negedge clk);
    check("sticky_nwrites", got_q.size(), 2);
    check("sticky_err", o_err, 1);
    check("sticky_done", o_done, 0);

    // Short low glitch while idle must not produce a byte.
    do_reset();
    uart_rx = 1'b0;
    repeat (3) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_cpu_rst", o_cpu_rst, 1);
    check("glitch_err", o_err, 0);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b1);
    repeat (30) @(negedge clk);
    check("glitch_then_n0_done", o_done, 1);
    check("glitch_then_n0_err", o_err, 0);
    check("glitch_nwrites", got_q.size(), 0);

    // Reset midway through a word, then a fresh N=1 frame.
    do_reset();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b1);
    uart_rx = 1'b0;
    repeat (20) @(negedge clk);
    rst     = 1'b1;
    uart_rx = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_we", o_we, 0);
    check("midrst_waddr", o_waddr, 0);
    check("midrst_wdata", o_wdata, 0);
    check("midrst_cpu_rst", o_cpu_rst, 1);
    check("midrst_done", o_done, 0);
    check("midrst_err", o_err, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    got_q.delete();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hCC, 1'b1);
    send_byte(8'hDD, 1'b1);
    send_byte(8'h01, 1'b1);
    repeat (30) @(negedge clk);
    check("after_rst_nwrites", got_q.size(), 1);
    if (got_q.size() == 1) begin
      check("after_rst_addr", got_q[0].addr, 0);
      check("after_rst_data", got_q[0].data, 32'hDDCC_BBAA);
    end
    check("after_rst_done", o_done, 1);

    // Randomized frames against a frame-level model; good frames chain without reset.
    prev_err = 1'b1;
    for (int it = 0; it < 10; it++) begin
      if (prev_err) do_reset();
      got_q.delete();
      n_words = (it == 0) ? 16 : int'($urandom_range(0, 18));
      corrupt = ($urandom_range(0, 3) == 0);
      words.delete();
      fr.delete();
      fr.push_back(n_words[7:0]);
      fr.push_back(n_words[15:8]);
      if (n_words <= 16) begin
        for (int w = 0; w < n_words; w++) begin
          words.push_back($urandom);
          for (int k = 0; k < 4; k++) fr.push_back(words[w][8*k +: 8]);
        end
        csum = 8'h00;
        foreach (fr[k]) csum = csum ^ fr[k];
        fr.push_back(corrupt ? (csum ^ 8'h5A) : csum);
        exp_done = !corrupt;
      end else begin
        fr.push_back(8'h12);
        fr.push_back(8'h34);
        exp_done = 1'b0;
      end
      exp_err = !exp_done;

      send_byte(fr[0], 1'b1);
      repeat (2) @(negedge clk);
      if (!prev_err) begin
        check($sformatf("rnd%0d_reenter_cpu_rst", it), o_cpu_rst, 1);
        check($sformatf("rnd%0d_reenter_done", it), o_done, 0);
      end
      for (int k = 1; k < fr.size(); k++) send_byte(fr[k], 1'b1);
      repeat (30) @(negedge clk);

      check($sformatf("rnd%0d_nwrites", it), got_q.size(), words.size());
      for (int w = 0; w < words.size() && w < got_q.size(); w++) begin
        check($sformatf("rnd%0d_w%0d_addr", it, w), got_q[w].addr, w % 16);
        check($sformatf("rnd%0d_w%0d_data", it, w), got_q[w].data, words[w]);
      end
      check($sformatf("rnd%0d_done", it), o_done, exp_done);
      check($sformatf("rnd%0d_err", it), o_err, exp_err);
      check($sformatf("rnd%0d_cpu_rst", it), o_cpu_rst, !exp_done);
      prev_err = exp_err;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
